// File: rtl/i2c_slave_rx_ctrl.sv
// Receive-side I2C slave controller: detects START/STOP, strobes an external
// MSB-first shift register, ACKs its write address and accepted data bytes.
module i2c_slave_rx_ctrl #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_BITS   = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl,
  input  logic       sda_in,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       shift_enable,
  output logic       sda_out_low,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    DATA      = 3'd3,
    DATA_ACK  = 3'd4,
    WAIT_STOP = 3'd5
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(NUM_BITS - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       full_q, full_d;
  logic       scl_q, sda_q;
  logic       sda_low_q, sda_low_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] rx_byte_q, rx_byte_d;

  logic scl_rise, scl_fall, start_cond, stop_cond;

  assign scl_rise   = scl & ~scl_q;
  assign scl_fall   = ~scl & scl_q;
  assign start_cond = scl & scl_q & sda_q & ~sda_in;
  assign stop_cond  = scl & scl_q & ~sda_q & sda_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      full_q       <= 1'b0;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      sda_low_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      full_q       <= full_d;
      scl_q        <= scl;
      sda_q        <= sda_in;
      sda_low_q    <= sda_low_d;
      byte_valid_q <= byte_valid_d;
      rx_byte_q    <= rx_byte_d;
    end
  end

  // full_q marks that all bits of the byte are in, so the following SCL fall
  // is the ACK decision rather than the fall that ends the START condition.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    full_d       = full_q;
    sda_low_d    = sda_low_q;
    byte_valid_d = 1'b0;
    rx_byte_d    = rx_byte_q;
    shift_enable = 1'b0;
    if (start_cond) begin
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      full_d    = 1'b0;
      sda_low_d = 1'b0;
    end else if (stop_cond) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      full_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (scl_rise && !full_q) begin
            shift_enable = 1'b1;
            bit_cnt_d    = bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) full_d = 1'b1;
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            if (state_q == ADDR) begin
              // Only writes to our address are ACKed; reads are NACKed.
              if (rx_data[7:1] == SLAVE_ADDR && !rx_data[0]) begin
                sda_low_d = 1'b1;
                state_d   = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end else if (rx_ready) begin
              byte_valid_d = 1'b1;
              rx_byte_d    = rx_data;
              sda_low_d    = 1'b1;
              state_d      = DATA_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK, DATA_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
            bit_cnt_d = 3'd0;
            state_d   = DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_out_low = sda_low_q;
  assign byte_valid  = byte_valid_q;
  assign rx_byte     = rx_byte_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_slave_rx_ctrl.sv
// Bench for i2c_slave_rx_ctrl: an I2C master driver, a shift register model,
// a transaction-level reference model and a byte scoreboard.
module tb_i2c_slave_rx_ctrl;

  logic       clk;
  logic       n_rst;
  logic       scl;
  logic       sda_m;
  logic       sda_in;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       shift_enable;
  logic       sda_out_low;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       busy;
  logic [2:0] dbg_state;

  i2c_slave_rx_ctrl #(.SLAVE_ADDR(7'h50), .NUM_BITS(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .scl         (scl),
    .sda_in      (sda_in),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .shift_enable(shift_enable),
    .sda_out_low (sda_out_low),
    .byte_valid  (byte_valid),
    .rx_byte     (rx_byte),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Open-drain bus: the line is low if either side pulls it low.
  assign sda_in = sda_m & ~sda_out_low;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External MSB-first serial-to-parallel shift register.
  logic [7:0] sr;
  initial sr = 8'h00;
  always @(posedge clk) if (shift_enable) sr <= {sr[6:0], sda_in};
  assign rx_data = sr;

  int total = 0;
  int bad   = 0;
  int shift_cnt = 0;
  logic [7:0] exp_q[$];

  // Reference model state, at transaction level.
  logic       listening = 1'b0;
  logic       is_addr   = 1'b0;
  logic [7:0] last_byte = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (shift_enable) shift_cnt++;
    if (n_rst && byte_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL byte_valid_unexpected: got rx_byte %0h expected no strobe at %0t", rx_byte, $time);
      end else begin
        check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;  wait_cyc(3);
    scl   = 1'b1; wait_cyc(4);
    scl   = 1'b0; wait_cyc(3);
  endtask

  task automatic do_start();
    sda_m = 1'b1; wait_cyc(3);
    scl   = 1'b1; wait_cyc(3);
    sda_m = 1'b0; wait_cyc(3);
    scl   = 1'b0; wait_cyc(3);
    listening = 1'b1;
    is_addr   = 1'b1;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_sda_low", {31'd0, sda_out_low}, 32'd0);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_cyc(3);
    scl   = 1'b1; wait_cyc(3);
    sda_m = 1'b1; wait_cyc(3);
    listening = 1'b0;
    is_addr   = 1'b0;
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_sda_low", {31'd0, sda_out_low}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    logic ack;
    int   s0;
    int   exp_shift;
    if (is_addr) ack = listening && (b[7:1] == 7'h50) && !b[0];
    else         ack = listening && rdy;
    exp_shift = listening ? 8 : 0;
    if (!is_addr && ack) begin
      exp_q.push_back(b);
      last_byte = b;
    end
    rx_ready = rdy;
    s0 = shift_cnt;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; wait_cyc(3);
    scl   = 1'b1; wait_cyc(2);
    check("ack", {31'd0, sda_out_low}, {31'd0, ack});
    check("rx_byte_hold", {24'd0, rx_byte}, {24'd0, last_byte});
    wait_cyc(2);
    scl = 1'b0; wait_cyc(3);
    check("shift_pulses", shift_cnt - s0, exp_shift);
    check("ack_release", {31'd0, sda_out_low}, 32'd0);
    listening = ack;
    is_addr   = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_shift_enable", {31'd0, shift_enable}, 32'd0);
    check("rst_sda_out_low", {31'd0, sda_out_low}, 32'd0);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; scl = 1'b1; sda_m = 1'b1; rx_ready = 1'b0;
    #2;
    check_reset_outputs();
    wait_cyc(3);
    n_rst = 1'b1;
    wait_cyc(3);

    // Addressed write, two accepted bytes.
    do_start();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    do_stop();

    // Wrong address, then read request: both ignored.
    do_start();
    send_byte(8'hA2, 1'b1);
    send_byte(8'h11, 1'b1);
    do_stop();
    do_start();
    send_byte(8'hA1, 1'b1);
    send_byte(8'h22, 1'b1);
    do_stop();

    // Downstream not ready: NACK, rx_byte keeps the prior byte.
    do_start();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h77, 1'b1);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h12, 1'b1);
    do_stop();

    // Repeated START after four data bits.
    do_start();
    send_byte(8'hA0, 1'b1);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b0); put_bit(1'b1);
    do_start();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h5A, 1'b1);
    do_stop();

    // Reset in the middle of a data byte.
    do_start();
    send_byte(8'hA0, 1'b1);
    put_bit(1'b1); put_bit(1'b1); put_bit(1'b0);
    n_rst = 1'b0;
    #2;
    check_reset_outputs();
    wait_cyc(3);
    n_rst = 1'b1;
    last_byte = 8'h00;
    listening = 1'b0;
    is_addr   = 1'b0;
    wait_cyc(2);
    do_stop();
    do_start();
    send_byte(8'hA0, 1'b1);
    send_byte(8'h96, 1'b1);
    do_stop();

    // Random transactions.
    for (int t = 0; t < 25; t++) begin
      logic [7:0] a;
      int nb;
      case ($urandom_range(0, 3))
        0: a = 8'hA0;
        1: a = 8'hA1;
        2: a = 8'hA2;
        default: a = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) a = 8'hA0;
      do_start();
      send_byte(a, 1'b1);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++)
        send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 3) != 0) do_stop();
    end
    do_stop();

    wait_cyc(5);
    check("exp_q_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_rx_ctrl.md
I2C_SLAVE_RX_CTRL -- requirements
Module: i2c_slave_rx_ctrl

Interface
REQ-001 Parameter: SLAVE_ADDR, default 7'h50, 7-bit address this slave answers to.
REQ-002 Parameter: NUM_BITS, default 8, data bits per byte; fixed at 8 for I2C.
REQ-003 Port: clk  in  1  system clock.
REQ-004 Port: n_rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: scl  in  1  I2C clock, already synchronized to clk.
REQ-006 Port: sda_in  in  1  I2C data, already synchronized to clk.
REQ-007 Port: rx_data  in  8  parallel_out of the MSB-first serial-to-parallel shift register; its serial_in is sda_in.
REQ-008 Port: rx_ready  in  1  downstream can accept a byte.
REQ-009 Port: shift_enable  out  1  single-cycle shift strobe to the shift register.
REQ-010 Port: sda_out_low  out  1  drive SDA low (ACK); 0 releases the line.
REQ-011 Port: byte_valid  out  1  single-cycle strobe; rx_byte holds a received data byte.
REQ-012 Port: rx_byte  out  8  last accepted data byte.
REQ-013 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-014 Edge detect: scl_q and sda_q hold the previous-cycle scl and sda_in; scl_rise = scl & ~scl_q; scl_fall = ~scl & scl_q.
REQ-015 START = scl & scl_q & sda_q & ~sda_in; STOP = scl & scl_q & ~sda_q & sda_in; an sda change in the same cycle as an scl edge is neither.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
REQ-017 START from any state: next state ADDR, bit_cnt = 0, sda_out_low = 0 (repeated start included); START has priority over every other transition.
REQ-018 STOP from any state: next state IDLE, bit_cnt = 0, sda_out_low = 0.
REQ-019 In ADDR and DATA: shift_enable = 1 in exactly the cycle scl_rise = 1, otherwise 0; bit_cnt increments on the same cycle.
REQ-020 shift_enable = 0 in IDLE, ADDR_ACK, DATA_ACK and WAIT_STOP.
REQ-021 bit_cnt is 3 bits; it saturates semantics via the FSM: after the 8th scl_rise (bit_cnt wraps 7->0), the next scl_fall performs the ACK decision.
REQ-022 ADDR ACK decision: if rx_data[7:1] == SLAVE_ADDR and rx_data[0] == 0, set sda_out_low = 1 and enter ADDR_ACK; otherwise sda_out_low stays 0 and enter WAIT_STOP.
REQ-023 Read requests (rx_data[0] == 1) are NACKed: sda_out_low stays 0, next state WAIT_STOP.
REQ-024 ADDR_ACK: hold sda_out_low = 1 through the 9th SCL pulse; on the next scl_fall clear sda_out_low, clear bit_cnt and enter DATA.
REQ-025 DATA ACK decision: if rx_ready = 1, pulse byte_valid for one cycle, load rx_byte = rx_data, set sda_out_low = 1 and enter DATA_ACK; if rx_ready = 0, no byte_valid, sda_out_low stays 0, enter WAIT_STOP.
REQ-026 DATA_ACK: on the next scl_fall clear sda_out_low, clear bit_cnt and return to DATA for the next byte.
REQ-027 WAIT_STOP: ignore scl edges; leave only on START or STOP.
REQ-028 rx_byte holds its value until the next accepted byte.
REQ-029 Latency: byte_valid asserts in the cycle after the scl_fall that follows the 8th data scl_rise.
REQ-030 sda_out_low is registered; it never changes while scl = 1, except when cleared by START or STOP.

Reset
REQ-031 On n_rst = 0, immediately: state IDLE, bit_cnt 0, scl_q 1, sda_q 1, shift_enable 0, sda_out_low 0, byte_valid 0, rx_byte 8'h00, busy 0.
REQ-032 Reset asserted mid-transfer aborts the transfer; after release the block waits in IDLE for a new START.

Verification
REQ-033 START, address 0x50 + W (byte 0xA0): 8 shift_enable pulses, then sda_out_low = 1 for the ACK clock, state DATA.
REQ-034 After address ACK, send 0x3C with rx_ready = 1: byte_valid pulses once, rx_byte = 0x3C, ACK driven; a second byte 0xC3 gives rx_byte = 0xC3.
REQ-035 Address 0x51 + W, or 0x50 + R (0xA1): no ACK, state WAIT_STOP, no shift_enable until the next START.
REQ-036 Data byte 0xFF with rx_ready = 0: no byte_valid, sda_out_low stays 0, rx_byte keeps its previous value, state WAIT_STOP.
REQ-037 Repeated START after 4 data bits: bit_cnt = 0, state ADDR, sda_out_low = 0; a new address 0xA0 is ACKed normally.
REQ-038 n_rst pulsed low during a data byte: all outputs at reset values, busy = 0; a following STOP/START sequence works correctly.
